// File: rtl/chess_board_store.sv
`default_nettype none
// ============================================================================
// Module   : chess_board_store
// Brief    : Board-state store with self-loading start position and a
//            WRITE/MOVE/UNDO command port. Define CHESS_BOARD_UNDO_EN to
//            build the undo history; without it UNDO is always rejected.
// Revision : 1.0 - initial release
// ============================================================================
module chess_board_store #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int PIECE_W    = 4,
  parameter int HIST_DEPTH = 16,
  localparam int N         = ROWS * COLS,
  localparam int ADDR_W    = $clog2(N),
  localparam int HC_W      = $clog2(HIST_DEPTH + 1)
) (
  input  logic                   full_clock,
  input  logic                   Reset,
  input  logic                   init_req,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_src,
  input  logic [ADDR_W-1:0]      cmd_dst,
  input  logic [PIECE_W-1:0]     cmd_piece,
  output logic [N*PIECE_W-1:0]   board_flat,
  output logic                   busy,
  output logic                   err,
  output logic [HC_W-1:0]        hist_count
);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_IDLE = 1'b1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_MOVE  = 2'b01;
  localparam logic [1:0] OP_UNDO  = 2'b10;

  localparam logic [ADDR_W:0]   c_num_sq  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] c_last_sq = ADDR_W'(N - 1);

  logic [0:0]          r_state;
  logic [ADDR_W-1:0]   r_scan;
  logic [PIECE_W-1:0]  r_board [N];
  logic                r_err;

  logic                w_accept;
  logic                w_src_ok;
  logic                w_dst_ok;
  logic [PIECE_W-1:0]  w_src_piece;
  logic                w_reject;
  logic                w_do_write;
  logic                w_do_move;
  logic                w_do_undo;
  logic                w_undo_ok;
  logic [ADDR_W-1:0]   w_undo_src;
  logic [ADDR_W-1:0]   w_undo_dst;
  logic [PIECE_W-1:0]  w_undo_cap;

  // Start position: back rank R N B Q K B N R repeats every 8 columns.
  function automatic logic [PIECE_W-1:0] start_piece(input logic [ADDR_W-1:0] a);
    int                 row;
    int                 col;
    logic [2:0]         rank_type;
    logic [PIECE_W-1:0] v;
    row = int'(a) / COLS;
    col = int'(a) % COLS;
    case (col % 8)
      0, 7:    rank_type = 3'd4;
      1, 6:    rank_type = 3'd2;
      2, 5:    rank_type = 3'd3;
      3:       rank_type = 3'd5;
      default: rank_type = 3'd6;
    endcase
    v = '0;
    if (row == 0)             v[3:0] = {1'b1, rank_type};
    else if (row == 1)        v[3:0] = 4'b1001;
    else if (row == ROWS - 2) v[3:0] = 4'b0001;
    else if (row == ROWS - 1) v[3:0] = {1'b0, rank_type};
    return v;
  endfunction

  assign cmd_ready = (r_state == S_IDLE) & ~init_req;
  assign busy      = (r_state == S_INIT);
  assign err       = r_err;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_src_ok    = ({1'b0, cmd_src} < c_num_sq);
  assign w_dst_ok    = ({1'b0, cmd_dst} < c_num_sq);
  assign w_src_piece = w_src_ok ? r_board[cmd_src] : '0;

  always_comb begin
    w_reject = 1'b0;
    case (cmd_op)
      OP_WRITE: w_reject = ~w_dst_ok;
      OP_MOVE:  w_reject = ~w_src_ok | ~w_dst_ok | (cmd_src == cmd_dst) |
                           (w_src_piece[2:0] == 3'b000);
      OP_UNDO:  w_reject = ~w_undo_ok;
      default:  w_reject = 1'b0;
    endcase
  end

  assign w_do_write = w_accept & ~w_reject & (cmd_op == OP_WRITE);
  assign w_do_move  = w_accept & ~w_reject & (cmd_op == OP_MOVE);
  assign w_do_undo  = w_accept & ~w_reject & (cmd_op == OP_UNDO);

`ifdef CHESS_BOARD_UNDO_EN
  localparam int               HP_W        = $clog2(HIST_DEPTH);
  localparam logic [HP_W-1:0]  c_hist_last = HP_W'(HIST_DEPTH - 1);
  localparam logic [HC_W-1:0]  c_hist_full = HC_W'(HIST_DEPTH);

  logic [ADDR_W-1:0]  r_h_src [HIST_DEPTH];
  logic [ADDR_W-1:0]  r_h_dst [HIST_DEPTH];
  logic [PIECE_W-1:0] r_h_cap [HIST_DEPTH];
  logic [HP_W-1:0]    r_wp;
  logic [HC_W-1:0]    r_count;
  logic [HP_W-1:0]    w_top;
  logic [PIECE_W-1:0] w_dst_piece;

  assign w_dst_piece = w_dst_ok ? r_board[cmd_dst] : '0;
  assign w_top       = (r_wp == '0) ? c_hist_last : r_wp - 1'b1;
  assign w_undo_ok   = (r_count != '0);
  assign w_undo_src  = r_h_src[w_top];
  assign w_undo_dst  = r_h_dst[w_top];
  assign w_undo_cap  = r_h_cap[w_top];
  assign hist_count  = r_count;

  // Write pointer wraps freely; a full buffer simply overwrites its oldest slot.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_wp    <= '0;
      r_count <= '0;
    end else if (init_req) begin
      r_wp    <= '0;
      r_count <= '0;
    end else if (w_do_move) begin
      r_wp    <= (r_wp == c_hist_last) ? '0 : r_wp + 1'b1;
      r_count <= (r_count == c_hist_full) ? r_count : r_count + 1'b1;
    end else if (w_do_undo) begin
      r_wp    <= w_top;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge full_clock) begin
    if (w_do_move) begin
      r_h_src[r_wp] <= cmd_src;
      r_h_dst[r_wp] <= cmd_dst;
      r_h_cap[r_wp] <= w_dst_piece;
    end
  end
`else
  assign w_undo_ok  = 1'b0;
  assign w_undo_src = '0;
  assign w_undo_dst = '0;
  assign w_undo_cap = '0;
  assign hist_count = '0;
`endif

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_INIT;
      r_scan  <= '0;
    end else if (init_req) begin
      r_state <= S_INIT;
      r_scan  <= '0;
    end else if (r_state == S_INIT) begin
      if (r_scan == c_last_sq) begin
        r_state <= S_IDLE;
        r_scan  <= '0;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_reject;
    end
  end

  // Load and commands are mutually exclusive: commands are only accepted in IDLE.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < N; k++) begin
        r_board[k] <= '0;
      end
    end else if (r_state == S_INIT) begin
      r_board[r_scan] <= start_piece(r_scan);
    end else if (w_do_write) begin
      r_board[cmd_dst] <= cmd_piece;
    end else if (w_do_move) begin
      r_board[cmd_dst] <= w_src_piece;
      r_board[cmd_src] <= '0;
    end else if (w_do_undo) begin
      r_board[w_undo_src] <= r_board[w_undo_dst];
      r_board[w_undo_dst] <= w_undo_cap;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < N; gk++) begin : g_flat
      assign board_flat[gk*PIECE_W +: PIECE_W] = r_board[gk];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chess_board_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_chess_board_store
// Brief    : Directed bench for chess_board_store (8x8 main instance plus an
//            8x9 instance for out-of-range addresses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chess_board_store;

  localparam int N   = 64;
  localparam int AW  = 6;
  localparam int HD  = 16;
  localparam int NB  = 72;
`ifdef CHESS_BOARD_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  logic            full_clock = 1'b0;
  logic            Reset;
  logic            init_req, cmd_valid, cmd_ready, busy, err;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_src, cmd_dst;
  logic [3:0]      cmd_piece;
  logic [N*4-1:0]  board_flat;
  logic [4:0]      hist_count;

  logic            b_init_req, b_cmd_valid, b_cmd_ready, b_busy, b_err;
  logic [1:0]      b_cmd_op;
  logic [6:0]      b_cmd_src, b_cmd_dst;
  logic [3:0]      b_cmd_piece;
  logic [NB*4-1:0] b_board_flat;
  logic [2:0]      b_hist_count;

  int checks = 0;
  int errors = 0;

  chess_board_store #(.ROWS(8), .COLS(8), .PIECE_W(4), .HIST_DEPTH(HD)) dut (
    .full_clock(full_clock), .Reset(Reset), .init_req(init_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_piece(cmd_piece),
    .board_flat(board_flat), .busy(busy), .err(err), .hist_count(hist_count));

  chess_board_store #(.ROWS(8), .COLS(9), .PIECE_W(4), .HIST_DEPTH(4)) dut_b (
    .full_clock(full_clock), .Reset(Reset), .init_req(b_init_req),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .cmd_src(b_cmd_src), .cmd_dst(b_cmd_dst), .cmd_piece(b_cmd_piece),
    .board_flat(b_board_flat), .busy(b_busy), .err(b_err), .hist_count(b_hist_count));

  always #5 full_clock = ~full_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model of the main instance
  logic [3:0] mb [N];
  int         h_src[$];
  int         h_dst[$];
  logic [3:0] h_cap[$];

  typedef struct {
    logic [1:0] op;
    int         src;
    int         dst;
    logic [3:0] piece;
    int         sq;
    bit         en_err;
    logic [3:0] en_val;
    int         en_hist;
    bit         dis_err;
    logic [3:0] dis_val;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] start_sq(input int a, input int cols, input int rows);
    int r;
    int c;
    logic [2:0] br;
    r = a / cols;
    c = a % cols;
    case (c % 8)
      0, 7:    br = 3'd4;
      1, 6:    br = 3'd2;
      2, 5:    br = 3'd3;
      3:       br = 3'd5;
      default: br = 3'd6;
    endcase
    if (r == 0) return {1'b1, br};
    if (r == 1) return 4'b1001;
    if (r == rows - 2) return 4'b0001;
    if (r == rows - 1) return {1'b0, br};
    return 4'b0000;
  endfunction

  task automatic mdl_reset_start();
    for (int k = 0; k < N; k++) mb[k] = start_sq(k, 8, 8);
    h_src.delete();
    h_dst.delete();
    h_cap.delete();
  endtask

  function automatic logic [N*4-1:0] mdl_flat();
    logic [N*4-1:0] v;
    for (int k = 0; k < N; k++) v[k*4 +: 4] = mb[k];
    return v;
  endfunction

  function automatic logic [NB*4-1:0] start_flat_b();
    logic [NB*4-1:0] v;
    for (int k = 0; k < NB; k++) v[k*4 +: 4] = start_sq(k, 9, 8);
    return v;
  endfunction

  task automatic mdl_apply(input logic [1:0] op, input int s, input int d,
                           input logic [3:0] p, output bit e);
    int hs;
    int hdst;
    logic [3:0] hc;
    e = 1'b0;
    case (op)
      2'd0: if (d >= N) e = 1'b1; else mb[d] = p;
      2'd1: begin
        if (s >= N || d >= N || s == d || mb[s][2:0] == 3'b000) e = 1'b1;
        else begin
          if (UNDO_EN) begin
            h_src.push_back(s);
            h_dst.push_back(d);
            h_cap.push_back(mb[d]);
            if (h_src.size() > HD) begin
              void'(h_src.pop_front());
              void'(h_dst.pop_front());
              void'(h_cap.pop_front());
            end
          end
          mb[d] = mb[s];
          mb[s] = 4'h0;
        end
      end
      2'd2: begin
        if (!UNDO_EN || h_src.size() == 0) e = 1'b1;
        else begin
          hs   = h_src.pop_back();
          hdst = h_dst.pop_back();
          hc   = h_cap.pop_back();
          mb[hs]   = mb[hdst];
          mb[hdst] = hc;
        end
      end
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge with inputs still driven.
  task automatic run_cmd(input logic [1:0] op, input int s, input int d, input logic [3:0] p);
    bit e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = s[AW-1:0];
    cmd_dst   = d[AW-1:0];
    cmd_piece = p;
    #1;
    check("cmd_ready", cmd_ready, 1'b1);
    @(posedge full_clock);
    mdl_apply(op, s, d, p, e);
    #1;
    check("err vs model", err, e);
    check("hist vs model", hist_count, h_src.size());
    check("board vs model", board_flat, mdl_flat());
    @(negedge full_clock);
  endtask

  task automatic wait_load(input string name, input int exp_edges);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge full_clock);
      #1;
      n++;
    end
    check(name, n, exp_edges);
  endtask

  initial begin
    logic [N*4-1:0] exp2;
    int s;
    int d;

    //            op     src dst piece   sq  en_err en_val    h  dis_err dis_val
    vecs[0]  = '{2'd1, 52, 36, 4'h0,  36, 1'b0, 4'b0001, 1, 1'b0, 4'b0001};
    vecs[1]  = '{2'd1, 12, 28, 4'h0,  28, 1'b0, 4'b1001, 2, 1'b0, 4'b1001};
    vecs[2]  = '{2'd2,  0,  0, 4'h0,  28, 1'b0, 4'b0000, 1, 1'b1, 4'b1001};
    vecs[3]  = '{2'd2,  0,  0, 4'h0,  52, 1'b0, 4'b0001, 0, 1'b1, 4'b0000};
    vecs[4]  = '{2'd0,  0, 35, 4'hA,  35, 1'b0, 4'b1010, 0, 1'b0, 4'b1010};
    vecs[5]  = '{2'd1, 51, 35, 4'h0,  35, 1'b0, 4'b0001, 1, 1'b0, 4'b0001};
    vecs[6]  = '{2'd2,  0,  0, 4'h0,  35, 1'b0, 4'b1010, 0, 1'b1, 4'b0001};
    vecs[7]  = '{2'd2,  0,  0, 4'h0,  35, 1'b1, 4'b1010, 0, 1'b1, 4'b0001};
    vecs[8]  = '{2'd1, 20, 20, 4'h0,  20, 1'b1, 4'b0000, 0, 1'b1, 4'b0000};
    vecs[9]  = '{2'd1, 30,  5, 4'h0,   5, 1'b1, 4'b1011, 0, 1'b1, 4'b1011};
    vecs[10] = '{2'd3,  0,  0, 4'h0,   0, 1'b0, 4'b1100, 0, 1'b0, 4'b1100};
    vecs[11] = '{2'd0,  0,  0, 4'hD,   0, 1'b0, 4'b1101, 0, 1'b0, 4'b1101};
    vecs[12] = '{2'd1,  0,  1, 4'h0,   1, 1'b0, 4'b1101, 1, 1'b0, 4'b1101};
    vecs[13] = '{2'd2,  0,  0, 4'h0,   1, 1'b0, 4'b1010, 0, 1'b1, 4'b1101};

    Reset = 1'b1; init_req = 1'b0; cmd_valid = 1'b0;
    cmd_op = 2'd3; cmd_src = '0; cmd_dst = '0; cmd_piece = '0;
    b_init_req = 1'b0; b_cmd_valid = 1'b0;
    b_cmd_op = 2'd3; b_cmd_src = '0; b_cmd_dst = '0; b_cmd_piece = '0;
    repeat (3) @(negedge full_clock);

    check("reset board", board_flat, '0);
    check("reset busy", busy, 1'b1);
    check("reset hist", hist_count, 0);
    check("reset err", err, 1'b0);
    check("reset ready", cmd_ready, 1'b0);
    check("reset board B", b_board_flat, '0);

    Reset = 1'b0;
    wait_load("load edges", 64);
    @(negedge full_clock);
    check("ready after load", cmd_ready, 1'b1);
    mdl_reset_start();
    check("start board", board_flat, mdl_flat());
    check("sq0 black rook", board_flat[0*4 +: 4], 4'b1100);
    check("sq4 black king", board_flat[4*4 +: 4], 4'b1110);
    check("sq52 white pawn", board_flat[52*4 +: 4], 4'b0001);
    check("sq60 white king", board_flat[60*4 +: 4], 4'b0110);
    check("rows 2..5 empty", board_flat[191:64], '0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].piece);
      check($sformatf("vec%0d err", i), err, UNDO_EN ? vecs[i].en_err : vecs[i].dis_err);
      check($sformatf("vec%0d square", i), board_flat[vecs[i].sq*4 +: 4],
            UNDO_EN ? vecs[i].en_val : vecs[i].dis_val);
      check($sformatf("vec%0d hist", i), hist_count, UNDO_EN ? vecs[i].en_hist : 0);
    end
    cmd_valid = 1'b0;
    @(posedge full_clock); #1;
    check("err pulse ends", err, 1'b0);
    @(negedge full_clock);

    // init_req beats a simultaneous WRITE, then Reset lands mid-load
    init_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 6'd40; cmd_piece = 4'hF;
    #1;
    check("ready low on init_req", cmd_ready, 1'b0);
    @(posedge full_clock); #1;
    check("busy after init_req", busy, 1'b1);
    check("hist cleared", hist_count, 0);
    check("no err on init_req", err, 1'b0);
    check("write not taken", board_flat[40*4 +: 4], 4'h0);
    init_req = 1'b0; cmd_valid = 1'b0;
    repeat (10) @(posedge full_clock);
    #2 Reset = 1'b1;
    #1;
    check("async reset board", board_flat, '0);
    check("async reset busy", busy, 1'b1);
    @(negedge full_clock);
    Reset = 1'b0;
    repeat (20) @(posedge full_clock);
    @(negedge full_clock);
    init_req = 1'b1;
    @(posedge full_clock); #1;
    init_req = 1'b0;
    wait_load("restart edges", 64);
    @(negedge full_clock);
    mdl_reset_start();
    check("board after restart", board_flat, mdl_flat());
    check("sq40 after restart", board_flat[40*4 +: 4], 4'h0);
    check("hist after restart", hist_count, 0);

    // 18 moves (last one a capture), 16 undos, one more undo
    for (int j = 0; j < 18; j++) begin
      if (j < 8)       begin s = 48 + j; d = 40 + j; end
      else if (j < 16) begin s = j;      d = j + 8;  end
      else if (j == 16) begin s = 40;    d = 32;     end
      else             begin s = 32;     d = 16;     end
      run_cmd(2'd1, s, d, 4'h0);
      check($sformatf("move%0d err", j), err, 1'b0);
      check($sformatf("move%0d hist", j), hist_count,
            UNDO_EN ? ((j + 1 > HD) ? HD : j + 1) : 0);
    end
    for (int j = 0; j < 16; j++) begin
      run_cmd(2'd2, 0, 0, 4'h0);
      check($sformatf("undo%0d err", j), err, UNDO_EN ? 1'b0 : 1'b1);
      check($sformatf("undo%0d hist", j), hist_count, UNDO_EN ? 15 - j : 0);
    end
`ifdef CHESS_BOARD_UNDO_EN
    for (int k = 0; k < N; k++) exp2[k*4 +: 4] = start_sq(k, 8, 8);
    exp2[40*4 +: 4] = 4'b0001;
    exp2[41*4 +: 4] = 4'b0001;
    exp2[48*4 +: 4] = 4'b0000;
    exp2[49*4 +: 4] = 4'b0000;
    check("board after 16 undos", board_flat, exp2);
`endif
    run_cmd(2'd2, 0, 0, 4'h0);
    check("17th undo err", err, 1'b1);
    cmd_valid = 1'b0;
    @(posedge full_clock); #1;
    check("err low after 17th undo", err, 1'b0);
    @(negedge full_clock);

    // 8x9 instance: address 72 is out of range
    check("B idle", b_busy, 1'b0);
    check("B start board", b_board_flat, start_flat_b());
    check("B sq8 black rook", b_board_flat[8*4 +: 4], 4'b1100);
    check("B sq71 white rook", b_board_flat[71*4 +: 4], 4'b0100);
    b_cmd_valid = 1'b1; b_cmd_op = 2'd0; b_cmd_dst = 7'd72; b_cmd_piece = 4'hF;
    #1;
    check("B ready", b_cmd_ready, 1'b1);
    @(posedge full_clock); #1;
    check("B write 72 err", b_err, 1'b1);
    check("B board after write 72", b_board_flat, start_flat_b());
    @(negedge full_clock);
    b_cmd_op = 2'd1; b_cmd_src = 7'd72; b_cmd_dst = 7'd0;
    @(posedge full_clock); #1;
    check("B move from 72 err", b_err, 1'b1);
    check("B board after move 72", b_board_flat, start_flat_b());
    @(negedge full_clock);
    b_cmd_op = 2'd0; b_cmd_dst = 7'd71; b_cmd_piece = 4'hD;
    @(posedge full_clock); #1;
    check("B write 71 err", b_err, 1'b0);
    check("B sq71 written", b_board_flat[71*4 +: 4], 4'hD);
    @(negedge full_clock);
    b_cmd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
